// File: rtl/chacha_seq_pkg.sv
// Shared types and widths for the ChaCha20-Poly1305 message sequencer.
// The state enum is exported so the debug state output can be decoded by name.
package chacha_seq_pkg;

    localparam int KEY_W       = 256;
    localparam int NONCE_W     = 96;
    localparam int BLK_W       = 512;
    localparam int TAG_W       = 128;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        INIT     = 4'd1,
        WAIT_RDY = 4'd2,
        LOAD     = 4'd3,
        NEXT     = 4'd4,
        WAIT_VAL = 4'd5,
        OUT      = 4'd6,
        FINAL    = 4'd7,
        WAIT_TAG = 4'd8,
        TAGOUT   = 4'd9,
        ERR      = 4'd10
    } state_t;

    // States in which the sequencer is blocked on the core and the watchdog runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == WAIT_RDY) || (s == WAIT_VAL) || (s == WAIT_TAG);
    endfunction

endpackage

// File: rtl/chacha_seq_watchdog.sv
// Per-step watchdog: restarts on every state change, counts while enabled and
// flags expiry on the last tolerated waiting cycle.
module chacha_seq_watchdog
    import chacha_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    // Expiry holds the counter so it never wraps if the state is held.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_q <= '0;
        end else if (count_en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = count_en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/chacha20_poly1305_seq.sv
// Message-level sequencer: takes one job descriptor, streams blocks through
// the ChaCha20-Poly1305 core with init/next/done pulses and returns the tag.
module chacha20_poly1305_seq
    import chacha_seq_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    // job descriptor
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_encdec,
    input  logic [KEY_W-1:0]   job_key,
    input  logic [NONCE_W-1:0] job_nonce,
    input  logic [CNT_W-1:0]   job_nblk,
    // input block stream
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   in_data,
    // output block stream
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_idx,
    // tag
    output logic               tag_valid,
    input  logic               tag_ready,
    output logic [TAG_W-1:0]   tag,
    output logic               err,
    // core interface
    output logic               core_init,
    output logic               core_next,
    output logic               core_done,
    output logic               core_encdec,
    output logic [KEY_W-1:0]   core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [BLK_W-1:0]   core_data_in,
    input  logic               core_ready,
    input  logic               core_valid,
    input  logic               core_tag_ok,
    input  logic [BLK_W-1:0]   core_data_out,
    input  logic [TAG_W-1:0]   core_tag,
    // debug
    output state_t             dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never depends combinationally on ready.

    state_t               state_q, state_n;
    logic                 encdec_q;
    logic [KEY_W-1:0]     key_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [CNT_W-1:0]     nblk_q;
    logic [CNT_W-1:0]     idx_q;
    logic [CNT_W-1:0]     idx_inc;
    logic [BLK_W-1:0]     din_q;
    logic [BLK_W-1:0]     dout_q;
    logic [CNT_W-1:0]     out_idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 err_q;
    logic                 job_acc;
    logic                 wd_restart;
    logic                 wd_count;
    logic                 wd_expired;

    assign job_acc = job_valid && job_ready;
    assign idx_inc = idx_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE, ERR: begin
                if (job_valid) state_n = INIT;
            end
            INIT: state_n = WAIT_RDY;
            WAIT_RDY: begin
                if (core_ready) begin
                    state_n = (idx_q == nblk_q) ? FINAL : LOAD;
                end else if (wd_expired) begin
                    state_n = ERR;
                end
            end
            LOAD: begin
                if (in_valid) state_n = NEXT;
            end
            NEXT: state_n = WAIT_VAL;
            WAIT_VAL: begin
                if (core_valid) begin
                    state_n = OUT;
                end else if (wd_expired) begin
                    state_n = ERR;
                end
            end
            // The last block goes straight to FINAL so idx never has to
            // reach nblk + 1, which keeps nblk = 2^CNT_W-1 wrap-free.
            OUT: begin
                if (out_ready) state_n = (idx_inc == nblk_q) ? FINAL : WAIT_RDY;
            end
            FINAL: state_n = WAIT_TAG;
            WAIT_TAG: begin
                if (core_tag_ok) begin
                    state_n = TAGOUT;
                end else if (wd_expired) begin
                    state_n = ERR;
                end
            end
            TAGOUT: begin
                if (tag_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Descriptor and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            encdec_q <= 1'b0;
            key_q    <= '0;
            nonce_q  <= '0;
            nblk_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (job_acc) begin
                encdec_q <= job_encdec;
                key_q    <= job_key;
                nonce_q  <= job_nonce;
                nblk_q   <= job_nblk;
                err_q    <= 1'b0;
            end
            if (state_n == ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // Block index and the one-deep input/output/tag buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            out_idx_q <= '0;
            tag_q     <= '0;
        end else begin
            if (job_acc) begin
                idx_q <= '0;
            end else if (state_q == OUT && out_ready) begin
                idx_q <= idx_inc;
            end
            if (state_q == LOAD && in_valid) begin
                din_q <= in_data;
            end
            if (state_q == WAIT_VAL && core_valid) begin
                dout_q    <= core_data_out;
                out_idx_q <= idx_q;
            end
            if (state_q == WAIT_TAG && core_tag_ok) begin
                tag_q <= core_tag;
            end
        end
    end

    assign wd_count   = is_wait_state(state_q);
    assign wd_restart = (state_n != state_q);

    chacha_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .restart  (wd_restart),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    // Every control output is a pure decode of the registered state, so each
    // pulse lasts exactly one cycle and at most one is high at a time.
    assign job_ready    = (state_q == IDLE) || (state_q == ERR);
    assign in_ready     = (state_q == LOAD);
    assign out_valid    = (state_q == OUT);
    assign tag_valid    = (state_q == TAGOUT);
    assign core_init    = (state_q == INIT);
    assign core_next    = (state_q == NEXT);
    assign core_done    = (state_q == FINAL);
    assign err          = err_q;
    assign out_data     = dout_q;
    assign out_idx      = out_idx_q;
    assign tag          = tag_q;
    assign core_encdec  = encdec_q;
    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign core_data_in = din_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_chacha20_poly1305_seq.sv
// Bench for the message sequencer: a behavioural core stub, randomized jobs and
// a reference model that predicts output blocks, indices and tag per job.
module tb_chacha20_poly1305_seq;
    import chacha_seq_pkg::*;

    localparam int CNT_W = 16;
    localparam int TMO   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               job_valid, job_ready, job_encdec;
    logic [KEY_W-1:0]   job_key;
    logic [NONCE_W-1:0] job_nonce;
    logic [CNT_W-1:0]   job_nblk;
    logic               in_valid, in_ready;
    logic [BLK_W-1:0]   in_data;
    logic               out_valid, out_ready;
    logic [BLK_W-1:0]   out_data;
    logic [CNT_W-1:0]   out_idx;
    logic               tag_valid, tag_ready;
    logic [TAG_W-1:0]   tag;
    logic               err;
    logic               core_init, core_next, core_done, core_encdec;
    logic [KEY_W-1:0]   core_key;
    logic [NONCE_W-1:0] core_nonce;
    logic [BLK_W-1:0]   core_data_in;
    logic               core_ready, core_valid, core_tag_ok;
    logic [BLK_W-1:0]   core_data_out;
    logic [TAG_W-1:0]   core_tag;
    state_t             dbg_state;

    chacha20_poly1305_seq #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_encdec(job_encdec),
        .job_key(job_key), .job_nonce(job_nonce), .job_nblk(job_nblk),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .err(err),
        .core_init(core_init), .core_next(core_next), .core_done(core_done),
        .core_encdec(core_encdec), .core_key(core_key), .core_nonce(core_nonce),
        .core_data_in(core_data_in), .core_ready(core_ready), .core_valid(core_valid),
        .core_tag_ok(core_tag_ok), .core_data_out(core_data_out), .core_tag(core_tag),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [BLK_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_idx_q[$];
    logic [BLK_W-1:0] acc_in_q[$];
    logic [TAG_W-1:0] exp_tag, got_tag, tag1;

    // job under test
    logic [BLK_W-1:0]   blk_mem [0:7];
    logic               j_enc;
    logic [KEY_W-1:0]   j_key;
    logic [NONCE_W-1:0] j_nonce;
    int                 j_nblk;

    // driver / monitor bookkeeping
    int cyc = 0;
    bit active, job_pend, job_done, stall_pend, out_rand;
    int in_ptr, in_wait, in_delay, stall_left, next_at_stall;
    int hs_cyc, next_cyc, err_cyc, job_acc_cyc;
    int n_init, n_next, n_done, n_overlap, n_inr, n_outv, n_outacc, n_tag, n_unstable;
    bit err_prev, last_out_held, last_tag_held, prev_core_valid;
    logic [BLK_W-1:0] last_out_data;
    logic [CNT_W-1:0] last_out_idx;
    logic [TAG_W-1:0] last_tag;

    // core stub state
    int lat_lo = 1, lat_hi = 3, busy = 0, kind = 0, ks_ctr = 0;
    bit no_valid = 0;
    logic [BLK_W-1:0]   held_in;
    logic [TAG_W-1:0]   t_acc;
    logic [KEY_W-1:0]   s_key;
    logic [NONCE_W-1:0] s_nonce;
    bit                 s_enc;

    task automatic check_eq(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference functions ----------------
    function automatic logic [BLK_W-1:0] keystream(input logic [KEY_W-1:0] k,
                                                   input logic [NONCE_W-1:0] n, input int i);
        logic [BLK_W-1:0] r;
        for (int w = 0; w < 16; w++)
            r[32*w +: 32] = k[32*(w%8) +: 32] ^ n[32*(w%3) +: 32] ^ (32'(i) * 32'h9e3779b9 + 32'(w));
        return r;
    endfunction

    function automatic logic [TAG_W-1:0] mac_step(input logic [TAG_W-1:0] a, input logic [BLK_W-1:0] ct);
        return {a[TAG_W-2:0], a[TAG_W-1]} ^ ct[127:0] ^ ct[255:128] ^ ct[383:256] ^ ct[511:384];
    endfunction

    // Expected ciphertext/plaintext blocks, indices and tag for the whole job.
    task automatic build_expect();
        logic [BLK_W-1:0] o;
        logic [TAG_W-1:0] a;
        exp_q.delete();
        exp_idx_q.delete();
        a = '0;
        for (int i = 0; i < j_nblk; i++) begin
            o = blk_mem[i] ^ keystream(j_key, j_nonce, i);
            exp_q.push_back(o);
            exp_idx_q.push_back(CNT_W'(i));
            a = mac_step(a, j_enc ? o : blk_mem[i]);
        end
        exp_tag = a ^ j_key[127:0] ^ {j_nonce, 32'(j_nblk)};
    endtask

    function automatic int lat();
        return int'($urandom_range(lat_hi, lat_lo));
    endfunction

    // ---------------- one clock cycle: core stub, drivers, monitors ----------------
    task automatic cycle_step();
        int pulses;
        logic [BLK_W-1:0] ct;
        @(posedge clk);
        #1;
        cyc++;
        core_valid  = 1'b0;
        core_tag_ok = 1'b0;
        if (prev_core_valid) check_eq("outv_after_core_valid", out_valid, 1'b1);
        if (job_acc_cyc >= 0 && cyc == job_acc_cyc + 1) begin
            check_eq("init_after_accept", core_init, 1'b1);
            check_eq("err_cleared", err, 1'b0);
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;

        pulses = int'(core_init) + int'(core_next) + int'(core_done);
        if (pulses > 1) n_overlap++;
        if (core_init) begin
            n_init++;
            check_eq("core_key", core_key, j_key);
            check_eq("core_nonce", core_nonce, j_nonce);
            check_eq("core_encdec_init", core_encdec, j_enc);
            s_key = core_key; s_nonce = core_nonce; s_enc = core_encdec;
            ks_ctr = 0; t_acc = '0; busy = lat(); kind = 1; core_ready = 1'b0;
        end else if (core_next) begin
            n_next++;
            next_cyc = cyc;
            check_eq("next_has_block", 512'(acc_in_q.size()), 512'd1);
            if (acc_in_q.size() > 0) check_eq("core_data_in", core_data_in, acc_in_q.pop_front());
            check_eq("core_encdec_next", core_encdec, j_enc);
            // core_next is driven in the cycle right after the accepting cycle.
            if (hs_cyc >= 0) check_eq("next_latency", 512'(cyc - hs_cyc), 512'd1);
            held_in = core_data_in; busy = lat(); kind = 2; core_ready = 1'b0;
        end else if (core_done) begin
            n_done++;
            busy = lat(); kind = 3; core_ready = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                case (kind)
                    1: core_ready = 1'b1;
                    2: begin
                        core_ready = 1'b1;
                        if (!no_valid) begin
                            core_valid    = 1'b1;
                            core_data_out = held_in ^ keystream(s_key, s_nonce, ks_ctr);
                            ct            = s_enc ? core_data_out : held_in;
                            t_acc         = mac_step(t_acc, ct);
                            ks_ctr++;
                        end
                    end
                    3: begin
                        core_ready  = 1'b1;
                        core_tag_ok = 1'b1;
                        core_tag    = t_acc ^ s_key[127:0] ^ {s_nonce, 32'(ks_ctr)};
                    end
                    default: ;
                endcase
            end
        end
        prev_core_valid = core_valid;

        // job driver
        if (job_pend) begin
            job_valid = 1'b1; job_encdec = j_enc; job_key = j_key;
            job_nonce = j_nonce; job_nblk = CNT_W'(j_nblk);
            if (job_ready) begin job_pend = 0; job_acc_cyc = cyc; end
        end else begin
            job_valid = 1'b0;
        end

        // input block driver
        if (in_ready) n_inr++;
        in_valid = 1'b0;
        if (active && in_ptr < j_nblk) begin
            if (in_ready && in_wait > 0) begin
                in_wait--;
            end else if (in_wait == 0) begin
                in_valid = 1'b1;
                in_data  = blk_mem[in_ptr];
                if (in_ready) begin
                    acc_in_q.push_back(in_data);
                    in_ptr++; hs_cyc = cyc; in_wait = in_delay;
                end
            end
        end

        // output monitor
        if (out_valid) begin
            n_outv++;
            if (stall_pend) begin stall_pend = 0; stall_left = 20; next_at_stall = n_next; end
            if (last_out_held && (out_data !== last_out_data || out_idx !== last_out_idx)) n_unstable++;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (stall_left == 0) check_eq("stall_no_next", 512'(n_next), 512'(next_at_stall));
        end else begin
            out_ready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_valid && out_ready) begin
            n_outacc++;
            if (exp_q.size() > 0) begin
                check_eq("out_data", out_data, exp_q.pop_front());
                check_eq("out_idx", out_idx, exp_idx_q.pop_front());
            end
        end
        last_out_held = out_valid && !out_ready;
        last_out_data = out_data;
        last_out_idx  = out_idx;

        // tag monitor
        tag_ready = tag_valid && (out_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (tag_valid && last_tag_held && tag !== last_tag) n_unstable++;
        if (tag_valid && tag_ready) begin got_tag = tag; n_tag++; job_done = 1; end
        last_tag_held = tag_valid && !tag_ready;
        last_tag      = tag;
    endtask

    task automatic clear_counts();
        n_init = 0; n_next = 0; n_done = 0; n_overlap = 0; n_inr = 0;
        n_outv = 0; n_outacc = 0; n_tag = 0; n_unstable = 0;
    endtask

    // Runs one job. abort_next > 0 stops after that many core_next pulses;
    // want_err stops at the rising edge of err.
    task automatic run_job(input string name, input int in_dly, input bit stall,
                           input bit rnd, input int abort_next, input bit want_err);
        bit ok;
        build_expect();
        clear_counts();
        acc_in_q.delete();
        job_pend = 1; active = 1; job_done = 0; in_ptr = 0;
        in_delay = in_dly; in_wait = in_dly; stall_pend = stall; stall_left = 0;
        out_rand = rnd; hs_cyc = -1; err_cyc = -1; job_acc_cyc = -1;
        for (int k = 0; k < 3000; k++) begin
            cycle_step();
            if (job_done) break;
            if (want_err && err_cyc >= 0) break;
            if (abort_next > 0 && n_next == abort_next) break;
        end
        ok = job_done || (want_err && err_cyc >= 0) || (abort_next > 0 && n_next == abort_next);
        check_eq({name, "_finished"}, ok, 1'b1);
        if (want_err) begin
            check_eq({name, "_err_latency"}, 512'(err_cyc - next_cyc), 512'd17);
            check_eq({name, "_err_job_ready"}, job_ready, 1'b1);
            check_eq({name, "_err_state"}, dbg_state, ERR);
            check_eq({name, "_err_nexts"}, 512'(n_next), 512'd1);
            active = 0;
        end else if (abort_next == 0) begin
            check_eq({name, "_n_init"}, 512'(n_init), 512'd1);
            check_eq({name, "_n_next"}, 512'(n_next), 512'(j_nblk));
            check_eq({name, "_n_done"}, 512'(n_done), 512'd1);
            check_eq({name, "_overlap"}, 512'(n_overlap), 512'd0);
            check_eq({name, "_out_count"}, 512'(n_outacc), 512'(j_nblk));
            check_eq({name, "_tag"}, got_tag, exp_tag);
            check_eq({name, "_n_tag"}, 512'(n_tag), 512'd1);
            check_eq({name, "_stable"}, 512'(n_unstable), 512'd0);
            check_eq({name, "_err"}, err, 1'b0);
            if (j_nblk == 0) begin
                check_eq({name, "_no_in_ready"}, 512'(n_inr), 512'd0);
                check_eq({name, "_no_out_valid"}, 512'(n_outv), 512'd0);
            end
            active = 0;
            cycle_step();
            check_eq({name, "_idle_after"}, job_ready, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_job_ready"}, job_ready, 1'b1);
        check_eq({name, "_in_ready"}, in_ready, 1'b0);
        check_eq({name, "_out_valid"}, out_valid, 1'b0);
        check_eq({name, "_tag_valid"}, tag_valid, 1'b0);
        check_eq({name, "_err"}, err, 1'b0);
        check_eq({name, "_pulses"}, {core_init, core_next, core_done}, 3'b000);
        check_eq({name, "_core_key"}, core_key, '0);
        check_eq({name, "_core_nonce"}, core_nonce, '0);
        check_eq({name, "_core_encdec"}, core_encdec, 1'b0);
        check_eq({name, "_core_data_in"}, core_data_in, '0);
        check_eq({name, "_out_data"}, out_data, '0);
        check_eq({name, "_out_idx"}, out_idx, '0);
        check_eq({name, "_tag_out"}, tag, '0);
        check_eq({name, "_state"}, dbg_state, IDLE);
    endtask

    task automatic set_spec_job(input bit enc, input int nb);
        logic [63:0] w;
        j_enc   = enc;
        j_key   = {4{64'h0123456789abcdef}};
        j_nonce = {32'h11111111, 32'h22222222, 32'h33333333};
        j_nblk  = nb;
        for (int i = 0; i < 8; i++) begin
            w = 64'hcafebabedeadbeef + 64'(i);
            blk_mem[i] = {8{w}};
        end
    endtask

    task automatic set_random_job(input int nb);
        j_enc   = 1'($urandom_range(0, 1));
        j_nblk  = nb;
        for (int i = 0; i < 8; i++) j_key[32*i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) j_nonce[32*i +: 32] = $urandom;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 16; i++) blk_mem[b][32*i +: 32] = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        job_valid = 0; job_encdec = 0; job_key = '0; job_nonce = '0; job_nblk = '0;
        in_valid = 0; in_data = '0; out_ready = 0; tag_ready = 0;
        core_ready = 1'b1; core_valid = 0; core_tag_ok = 0; core_data_out = '0; core_tag = '0;
        active = 0; job_pend = 0; job_acc_cyc = -1; err_prev = 0;
        last_out_held = 0; last_tag_held = 0; prev_core_valid = 0;
        j_enc = 0; j_key = '0; j_nonce = '0; j_nblk = 0;
        clear_counts();
        repeat (3) cycle_step();
        check_reset_outputs("reset");
        reset = 1'b0;
        cycle_step();

        // encrypt, three fixed blocks, no backpressure
        set_spec_job(1'b1, 3);
        run_job("enc3", 0, 1'b0, 1'b0, 0, 1'b0);
        tag1 = got_tag;

        // same job, output held off for 20 cycles after block 0
        set_spec_job(1'b1, 3);
        run_job("enc3_stall", 0, 1'b1, 1'b0, 0, 1'b0);
        check_eq("stall_tag_matches", got_tag, tag1);

        // empty message
        set_spec_job(1'b1, 0);
        run_job("nblk0", 0, 1'b0, 1'b0, 0, 1'b0);

        // decrypt with late input blocks
        set_spec_job(1'b0, 2);
        run_job("dec2_late", 5, 1'b0, 1'b0, 0, 1'b0);

        // core never answers core_next -> watchdog error
        no_valid = 1;
        set_random_job(2);
        run_job("timeout", 0, 1'b0, 1'b0, 0, 1'b1);
        no_valid = 0;
        busy = 0;
        core_ready = 1'b1;

        // next job after the error clears err
        set_random_job(2);
        run_job("after_err", 1, 1'b0, 1'b1, 0, 1'b0);

        // reset while waiting for block 1 from the core
        lat_lo = 4; lat_hi = 4;
        set_random_job(3);
        run_job("abort", 0, 1'b0, 1'b0, 2, 1'b0);
        cycle_step();
        check_eq("abort_in_wait_val", dbg_state, WAIT_VAL);
        active = 0; busy = 0; core_ready = 1'b1;
        reset = 1'b1;
        cycle_step();
        check_reset_outputs("midreset");
        reset = 1'b0;
        clear_counts();
        repeat (10) cycle_step();
        check_eq("midreset_no_pulses", 512'(n_init + n_next + n_done), 512'd0);
        lat_lo = 1; lat_hi = 4;

        // randomized jobs with random backpressure and core latency
        for (int r = 0; r < 8; r++) begin
            set_random_job(int'($urandom_range(0, 6)));
            run_job("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
